// File: rtl/uart_axil_responder.sv
// AXI4-Lite UART register responder: DATA/STATUS/IER/SCRATCH registers,
// a TX byte FIFO toward the serializer and an RX byte FIFO from the deserializer.

module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    // Legality comes from the registered count, so a push into a full FIFO
    // is dropped even when a pop happens in the same cycle.
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end
endmodule

module uart_axil_responder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        chipset_clk,
    input  logic        chipset_rst,
    input  logic [12:0] uart_axi_awaddr,
    input  logic        uart_axi_awvalid,
    output logic        uart_axi_awready,
    input  logic [31:0] uart_axi_wdata,
    input  logic        uart_axi_wvalid,
    output logic        uart_axi_wready,
    output logic [1:0]  uart_axi_bresp,
    output logic        uart_axi_bvalid,
    input  logic        uart_axi_bready,
    input  logic [12:0] uart_axi_araddr,
    input  logic        uart_axi_arvalid,
    output logic        uart_axi_arready,
    output logic [31:0] uart_axi_rdata,
    output logic [1:0]  uart_axi_rresp,
    output logic        uart_axi_rvalid,
    input  logic        uart_axi_rready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_strobe,
    output logic        uart_irq
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] SEL_DATA    = 2'd0;
    localparam logic [1:0] SEL_STATUS  = 2'd1;
    localparam logic [1:0] SEL_IER     = 2'd2;
    localparam logic [1:0] SEL_SCRATCH = 2'd3;

    logic        aw_held_q, aw_held_d;
    logic [12:2] aw_addr_q, aw_addr_d;
    logic        w_held_q, w_held_d;
    logic [31:0] w_data_q, w_data_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  ier_q, ier_d;
    logic [31:0] scratch_q, scratch_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic        irq_q, irq_d;

    logic        aw_hs, w_hs, ar_hs, wr_fire;
    logic [12:2] wr_addr;
    logic [31:0] wr_data;
    logic        wr_hit, rd_hit;
    logic [1:0]  wr_sel, rd_sel;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_head;
    logic        sticky_clr;
    logic        unused_ok;

    assign unused_ok = &{1'b0, uart_axi_awaddr[1:0], uart_axi_araddr[1:0]};

    assign uart_axi_awready = ~aw_held_q & ~bvalid_q;
    assign uart_axi_wready  = ~w_held_q & ~bvalid_q;
    assign uart_axi_arready = ~rvalid_q;
    assign uart_axi_bvalid  = bvalid_q;
    assign uart_axi_bresp   = bresp_q;
    assign uart_axi_rvalid  = rvalid_q;
    assign uart_axi_rresp   = rresp_q;
    assign uart_axi_rdata   = rdata_q;
    assign uart_irq         = irq_q;

    assign aw_hs = uart_axi_awvalid & uart_axi_awready;
    assign w_hs  = uart_axi_wvalid & uart_axi_wready;
    assign ar_hs = uart_axi_arvalid & uart_axi_arready;

    // A beat arriving this cycle counts as held, giving single-cycle write latency.
    assign wr_fire = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    assign wr_addr = aw_held_q ? aw_addr_q : uart_axi_awaddr[12:2];
    assign wr_data = w_held_q ? w_data_q : uart_axi_wdata;
    assign wr_hit  = (wr_addr[12:4] == '0);
    assign wr_sel  = wr_addr[3:2];
    assign rd_hit  = (uart_axi_araddr[12:4] == '0);
    assign rd_sel  = uart_axi_araddr[3:2];

    assign tx_push    = wr_fire & wr_hit & (wr_sel == SEL_DATA);
    assign tx_valid   = ~tx_empty;
    assign tx_pop     = tx_valid & tx_ready;
    assign rx_pop     = ar_hs & rd_hit & (rd_sel == SEL_DATA);
    assign sticky_clr = ar_hs & rd_hit & (rd_sel == SEL_STATUS);

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (chipset_clk),
        .rst   (chipset_rst),
        .push  (tx_push),
        .din   (wr_data[7:0]),
        .pop   (tx_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .head  (tx_data)
    );

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (chipset_clk),
        .rst   (chipset_rst),
        .push  (rx_strobe),
        .din   (rx_data),
        .pop   (rx_pop),
        .full  (rx_full),
        .empty (rx_empty),
        .head  (rx_head)
    );

    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ier_d     = ier_q;
        scratch_d = scratch_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = uart_axi_awaddr[12:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = uart_axi_wdata;
        end
        if (bvalid_q && uart_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (wr_fire) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
            if (wr_hit && wr_sel == SEL_IER) begin
                ier_d = wr_data[1:0];
            end
            if (wr_hit && wr_sel == SEL_SCRATCH) begin
                scratch_d = wr_data;
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;

        if (rvalid_q && uart_axi_rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = '0;
            if (rd_hit) begin
                unique case (rd_sel)
                    SEL_DATA:    rdata_d = rx_empty ? 32'd0 : {24'd0, rx_head};
                    SEL_STATUS:  rdata_d = {26'd0, rx_ovr_q, tx_ovf_q, rx_full,
                                            tx_empty, tx_full, ~rx_empty};
                    SEL_IER:     rdata_d = {30'd0, ier_q};
                    SEL_SCRATCH: rdata_d = scratch_q;
                    default:     rdata_d = '0;
                endcase
            end
        end
    end

    // New overflow events win over a clearing STATUS read in the same cycle.
    always_comb begin
        tx_ovf_d = (tx_ovf_q & ~sticky_clr) | (tx_push & tx_full);
        rx_ovr_d = (rx_ovr_q & ~sticky_clr) | (rx_strobe & rx_full);
        irq_d    = (ier_q[0] & ~rx_empty) | (ier_q[1] & tx_empty);
    end

    always_ff @(posedge chipset_clk or posedge chipset_rst) begin
        if (chipset_rst) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            ier_q     <= '0;
            scratch_q <= '0;
            tx_ovf_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            ier_q     <= ier_d;
            scratch_q <= scratch_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovr_q  <= rx_ovr_d;
            irq_q     <= irq_d;
        end
    end
endmodule
